// File: rtl/sfp_mode_pkg.sv
// Shared definitions for the SFP mode selector: query FSM states and
// default parameter values.
package sfp_mode_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_DONE
   } query_state_t;

   localparam int unsigned DEF_NCH       = 4;
   localparam int unsigned DEF_DEB_CYC   = 20_000_000;
   localparam int unsigned DEF_RST_CYC   = 200_000;
   localparam int unsigned DEF_TO_CYC    = 2_000_000;
   localparam int unsigned DEF_RETRY_MAX = 3;
   localparam logic [6:0]  DEF_IIC_DAD   = 7'h50;
   localparam logic [7:0]  DEF_IIC_ADR   = 8'h06;
   localparam int unsigned DEF_MODE_BIT  = 3;

endpackage

// File: rtl/sfp_sigdet_debounce.sv
// Per-channel signal-detect synchroniser/debouncer and PHY reset pulse
// generator (pulse is held high through reset and RST_CYC cycles after).
module sfp_sigdet_debounce #(
   parameter int unsigned DEB_CYC = 20_000_000,
   parameter int unsigned RST_CYC = 200_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sig_det,
   input  logic pulse_req,
   output logic detect,
   output logic phy_rst
);

   localparam int unsigned DW = $clog2(DEB_CYC + 1);
   localparam int unsigned RW = $clog2(RST_CYC + 1);

   logic          sync1;
   logic          sync2;
   logic [DW-1:0] deb_cnt;
   logic [RW-1:0] rst_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         deb_cnt <= '0;
         detect  <= 1'b0;
      end else begin
         sync1 <= sig_det;
         sync2 <= sync1;
         if (!sync2) begin
            deb_cnt <= '0;
            detect  <= 1'b0;
         end else begin
            if (deb_cnt != DW'(DEB_CYC))
               deb_cnt <= deb_cnt + 1'b1;
            // rises on the DEB_CYC-th consecutive synced-high cycle
            if (deb_cnt >= DW'(DEB_CYC - 1))
               detect <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rst_cnt <= RW'(RST_CYC);
      else if (pulse_req)
         rst_cnt <= RW'(RST_CYC);
      else if (rst_cnt != '0)
         rst_cnt <= rst_cnt - 1'b1;
   end

   assign phy_rst = (rst_cnt != '0);

endmodule

// File: rtl/sfp_mode_select.sv
// SFP mode selector: debounced per-channel detect, round-robin IIC EEPROM
// query of the mode bit, and PHY reset on mode change.
module sfp_mode_select
   import sfp_mode_pkg::*;
#(
   parameter int unsigned NCH       = DEF_NCH,
   parameter int unsigned DEB_CYC   = DEF_DEB_CYC,
   parameter int unsigned RST_CYC   = DEF_RST_CYC,
   parameter int unsigned TO_CYC    = DEF_TO_CYC,
   parameter int unsigned RETRY_MAX = DEF_RETRY_MAX,
   parameter logic [6:0]  IIC_DAD   = DEF_IIC_DAD,
   parameter logic [7:0]  IIC_ADR   = DEF_IIC_ADR,
   parameter int unsigned MODE_BIT  = DEF_MODE_BIT
) (
   input  logic           CLK,
   input  logic           SYS_RSTn,
   input  logic [NCH-1:0] SIG_DET,
   output logic           IIC_REQ,
   output logic [2:0]     IIC_CH,
   output logic [6:0]     IIC_DAD_OUT,
   output logic [7:0]     IIC_ADR_OUT,
   input  logic           IIC_ACK,
   input  logic           IIC_RVL,
   input  logic [7:0]     IIC_RDT,
   input  logic           IIC_ERR,
   output logic [NCH-1:0] SEL_SGMII,
   output logic [NCH-1:0] PHY_RST,
   output logic [NCH-1:0] MODE_VALID,
   output logic [NCH-1:0] MODE_ERR
);

   localparam int unsigned TW = $clog2(TO_CYC + 1);
   localparam int unsigned RW = $clog2(RETRY_MAX + 1);

   query_state_t   state, state_nxt;
   logic [NCH-1:0] detect, det_q, rise, fall;
   logic [NCH-1:0] pend, done_ok, pulse_req;
   logic [RW-1:0]  retry [NCH];
   logic [2:0]     last_ch, pick_ch;
   logic           pick_found;
   logic [TW-1:0]  to_cnt;
   logic           got_rvl, mode_bit_q, lost;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      sfp_sigdet_debounce #(
         .DEB_CYC (DEB_CYC),
         .RST_CYC (RST_CYC)
      ) u_deb (
         .clk       (CLK),
         .rst_n     (SYS_RSTn),
         .sig_det   (SIG_DET[g]),
         .pulse_req (pulse_req[g]),
         .detect    (detect[g]),
         .phy_rst   (PHY_RST[g])
      );
   end

   assign rise        = detect & ~det_q;
   assign fall        = det_q & ~detect;
   assign IIC_REQ     = (state == ST_REQ);
   assign IIC_DAD_OUT = IIC_DAD;
   assign IIC_ADR_OUT = IIC_ADR;

   // first pending channel after last_ch, wrapping around
   always_comb begin
      pick_found = 1'b0;
      pick_ch    = '0;
      for (int unsigned k = 1; k <= NCH; k++)
         for (int unsigned i = 0; i < NCH; i++)
            if (!pick_found && pend[i] && (i == (32'(last_ch) + k) % NCH)) begin
               pick_found = 1'b1;
               pick_ch    = 3'(i);
            end
   end

   always_comb begin
      for (int unsigned i = 0; i < NCH; i++) begin
         done_ok[i]   = (state == ST_DONE) && (IIC_CH == 3'(i)) && !lost && detect[i];
         pulse_req[i] = done_ok[i] && got_rvl && (mode_bit_q != SEL_SGMII[i]);
      end
   end

   always_ff @(posedge CLK or negedge SYS_RSTn) begin
      if (!SYS_RSTn) state <= ST_IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (pick_found) state_nxt = ST_REQ;
         ST_REQ:  if (IIC_ACK) state_nxt = ST_WAIT;
         ST_WAIT: if (IIC_RVL || IIC_ERR || (to_cnt == TW'(TO_CYC - 1))) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge SYS_RSTn) begin
      if (!SYS_RSTn) begin
         IIC_CH     <= '0;
         last_ch    <= 3'(NCH - 1);
         to_cnt     <= '0;
         got_rvl    <= 1'b0;
         mode_bit_q <= 1'b0;
         lost       <= 1'b0;
         det_q      <= '0;
         pend       <= '0;
         SEL_SGMII  <= '0;
         MODE_VALID <= '0;
         MODE_ERR   <= '0;
         for (int unsigned i = 0; i < NCH; i++) retry[i] <= '0;
      end else begin
         det_q <= detect;
         case (state)
            ST_IDLE: if (pick_found) IIC_CH <= pick_ch;
            ST_WAIT: begin
               to_cnt <= to_cnt + 1'b1;
               if (IIC_RVL) begin
                  got_rvl    <= 1'b1;
                  mode_bit_q <= IIC_RDT[MODE_BIT];
               end else begin
                  got_rvl <= 1'b0;
               end
            end
            ST_DONE: last_ch <= IIC_CH;
            default: ;
         endcase
         if (state != ST_WAIT) to_cnt <= '0;

         if (state == ST_IDLE) lost <= 1'b0;
         for (int unsigned i = 0; i < NCH; i++) begin
            if (state != ST_IDLE && IIC_CH == 3'(i) && fall[i]) lost <= 1'b1;
            if (done_ok[i]) begin
               if (got_rvl) begin
                  SEL_SGMII[i]  <= mode_bit_q;
                  MODE_VALID[i] <= 1'b1;
                  pend[i]       <= 1'b0;
               end else begin
                  retry[i] <= retry[i] + 1'b1;
                  if (retry[i] >= RW'(RETRY_MAX - 1)) begin
                     MODE_ERR[i] <= 1'b1;
                     pend[i]     <= 1'b0;
                  end
               end
            end
            // edge events take priority over a same-cycle query result
            if (rise[i]) begin
               pend[i]  <= 1'b1;
               retry[i] <= '0;
            end
            if (fall[i]) begin
               pend[i]       <= 1'b0;
               MODE_VALID[i] <= 1'b0;
               MODE_ERR[i]   <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_sfp_mode_select.sv
// Directed, table-driven bench for sfp_mode_select with short timing
// parameters (NCH=4, DEB_CYC=16, RST_CYC=8, TO_CYC=32, RETRY_MAX=3).
module tb_sfp_mode_select;

   logic       CLK = 1'b0;
   logic       SYS_RSTn;
   logic [3:0] SIG_DET;
   logic       IIC_REQ;
   logic [2:0] IIC_CH;
   logic [6:0] IIC_DAD_OUT;
   logic [7:0] IIC_ADR_OUT;
   logic       IIC_ACK, IIC_RVL, IIC_ERR;
   logic [7:0] IIC_RDT;
   logic [3:0] SEL_SGMII, PHY_RST, MODE_VALID, MODE_ERR;

   int n_checks = 0;
   int n_fail   = 0;

   sfp_mode_select #(
      .NCH       (4),
      .DEB_CYC   (16),
      .RST_CYC   (8),
      .TO_CYC    (32),
      .RETRY_MAX (3),
      .IIC_DAD   (7'h50),
      .IIC_ADR   (8'h06),
      .MODE_BIT  (3)
   ) dut (
      .CLK         (CLK),
      .SYS_RSTn    (SYS_RSTn),
      .SIG_DET     (SIG_DET),
      .IIC_REQ     (IIC_REQ),
      .IIC_CH      (IIC_CH),
      .IIC_DAD_OUT (IIC_DAD_OUT),
      .IIC_ADR_OUT (IIC_ADR_OUT),
      .IIC_ACK     (IIC_ACK),
      .IIC_RVL     (IIC_RVL),
      .IIC_RDT     (IIC_RDT),
      .IIC_ERR     (IIC_ERR),
      .SEL_SGMII   (SEL_SGMII),
      .PHY_RST     (PHY_RST),
      .MODE_VALID  (MODE_VALID),
      .MODE_ERR    (MODE_ERR)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [3:0] raise;
      logic [7:0] rdt;
      logic [2:0] ch;
      logic [3:0] sel;
      logic [3:0] valid;
      logic [3:0] pulse;
   } vec_t;

   vec_t tbl [4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_req(input logic [2:0] exp_ch, input string name);
      int n = 0;
      while (!IIC_REQ && n < 200) begin
         tick();
         n++;
      end
      chk({name, " req"}, 32'(IIC_REQ), 32'd1);
      chk({name, " ch"}, 32'(IIC_CH), 32'(exp_ch));
   endtask

   task automatic ack_req;
      tick();
      chk("req held", 32'(IIC_REQ), 32'd1);
      IIC_ACK = 1'b1;
      tick();
      IIC_ACK = 1'b0;
   endtask

   task automatic respond(input bit err, input logic [7:0] rdt);
      if (err) IIC_ERR = 1'b1;
      else begin
         IIC_RVL = 1'b1;
         IIC_RDT = rdt;
      end
      tick();
      IIC_RVL = 1'b0;
      IIC_ERR = 1'b0;
      tick();
   endtask

   task automatic pulse_len(input logic [3:0] mask, input string name);
      int n = 0;
      while ((PHY_RST & mask) != 4'h0 && n < 50) begin
         tick();
         n++;
      end
      chk(name, 32'(n), 32'd8);
   endtask

   initial begin
      int early;
      tbl[0] = '{raise: 4'b0100, rdt: 8'h08, ch: 3'd2, sel: 4'b0100, valid: 4'b0100, pulse: 4'b0100};
      tbl[1] = '{raise: 4'b1001, rdt: 8'h08, ch: 3'd3, sel: 4'b1100, valid: 4'b1100, pulse: 4'b1000};
      tbl[2] = '{raise: 4'b0000, rdt: 8'hF7, ch: 3'd0, sel: 4'b1100, valid: 4'b1101, pulse: 4'b0000};
      tbl[3] = '{raise: 4'b0010, rdt: 8'h08, ch: 3'd1, sel: 4'b1110, valid: 4'b1111, pulse: 4'b0010};

      SYS_RSTn = 1'b0;
      SIG_DET  = 4'h0;
      IIC_ACK  = 1'b0;
      IIC_RVL  = 1'b0;
      IIC_ERR  = 1'b0;
      IIC_RDT  = 8'h00;

      #23;
      chk("rst phy", 32'(PHY_RST), 32'hF);
      chk("rst req", 32'(IIC_REQ), 32'd0);
      chk("rst ch", 32'(IIC_CH), 32'd0);
      chk("rst sel", 32'(SEL_SGMII), 32'd0);
      chk("rst valid", 32'(MODE_VALID), 32'd0);
      chk("rst err", 32'(MODE_ERR), 32'd0);
      chk("dad", 32'(IIC_DAD_OUT), 32'h50);
      chk("adr", 32'(IIC_ADR_OUT), 32'h06);
      SYS_RSTn = 1'b1;
      pulse_len(4'hF, "rst phy len");
      chk("rst phy low", 32'(PHY_RST), 32'h0);

      for (int r = 0; r < 4; r++) begin
         SIG_DET = SIG_DET | tbl[r].raise;
         wait_req(tbl[r].ch, "row");
         ack_req();
         respond(1'b0, tbl[r].rdt);
         chk("row sel", 32'(SEL_SGMII), 32'(tbl[r].sel));
         chk("row valid", 32'(MODE_VALID), 32'(tbl[r].valid));
         chk("row err", 32'(MODE_ERR), 32'h0);
         chk("row phy", 32'(PHY_RST), 32'(tbl[r].pulse));
         if (tbl[r].pulse != 4'h0) pulse_len(tbl[r].pulse, "row phy len");
      end

      // ch1: error, timeout, error -> MODE_ERR after exactly three requests
      SIG_DET[1] = 1'b0;
      repeat (5) tick();
      chk("drop1 valid", 32'(MODE_VALID), 32'b1101);
      SIG_DET[1] = 1'b1;
      for (int a = 0; a < 3; a++) begin
         wait_req(3'd1, "retry");
         ack_req();
         if (a == 1) begin
            early = 0;
            repeat (30) begin
               tick();
               if (IIC_REQ) early++;
            end
            chk("timeout early req", 32'(early), 32'd0);
         end else begin
            respond(1'b1, 8'h00);
            chk("retry err", 32'(MODE_ERR), (a == 2) ? 32'b0010 : 32'b0000);
         end
      end
      chk("retry valid", 32'(MODE_VALID), 32'b1101);
      early = 0;
      repeat (60) begin
         tick();
         if (IIC_REQ) early++;
      end
      chk("no 4th req", 32'(early), 32'd0);
      IIC_RVL = 1'b1;
      IIC_ERR = 1'b1;
      IIC_RDT = 8'h08;
      tick();
      IIC_RVL = 1'b0;
      IIC_ERR = 1'b0;
      tick();
      chk("stray rsp err", 32'(MODE_ERR), 32'b0010);
      chk("stray rsp valid", 32'(MODE_VALID), 32'b1101);
      chk("stray rsp sel", 32'(SEL_SGMII), 32'b1110);
      SIG_DET[1] = 1'b0;
      repeat (5) tick();
      chk("drop clears err", 32'(MODE_ERR), 32'h0);
      SIG_DET[1] = 1'b1;
      wait_req(3'd1, "redetect");
      ack_req();
      respond(1'b0, 8'h08);
      chk("redetect valid", 32'(MODE_VALID), 32'b1111);
      chk("redetect sel", 32'(SEL_SGMII), 32'b1110);
      chk("same mode no pulse", 32'(PHY_RST), 32'h0);

      // ch0 lost while its query is in WAIT: result discarded
      SIG_DET[0] = 1'b0;
      repeat (5) tick();
      chk("drop0 valid", 32'(MODE_VALID), 32'b1110);
      SIG_DET[0] = 1'b1;
      wait_req(3'd0, "lost");
      ack_req();
      SIG_DET[0] = 1'b0;
      repeat (5) tick();
      respond(1'b0, 8'h08);
      chk("lost sel", 32'(SEL_SGMII), 32'b1110);
      chk("lost phy", 32'(PHY_RST), 32'h0);
      chk("lost valid", 32'(MODE_VALID), 32'b1110);
      repeat (3) tick();
      chk("lost phy later", 32'(PHY_RST), 32'h0);

      // asynchronous reset in the middle of a query
      SIG_DET[0] = 1'b1;
      wait_req(3'd0, "midrst");
      #2;
      SYS_RSTn = 1'b0;
      #1;
      chk("midrst req", 32'(IIC_REQ), 32'd0);
      chk("midrst phy", 32'(PHY_RST), 32'hF);
      chk("midrst sel", 32'(SEL_SGMII), 32'h0);
      chk("midrst valid", 32'(MODE_VALID), 32'h0);
      chk("midrst ch", 32'(IIC_CH), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
